// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the data-memory arbiter: memop codes, FSM states
// and the alignment rule applied before any memory strobe is issued.
package rv32_mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } arb_state_e;

    // Undefined memop codes are never flagged; they pass through to the memory.
    function automatic logic is_misaligned(input logic [2:0] memop,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (memop)
            MEMOP_H, MEMOP_HU: mis = addr_lo[0];
            MEMOP_W:           mis = (addr_lo != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-port grant logic for the data-memory arbiter. Holds the round-robin
// pointer; grants are only issued while the parent FSM allows it.
module dmem_rr_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic ptr_q;
    logic ptr_d;
    logic g0;
    logic g1;

    // The pointer names the port that wins a tie; it moves to the loser of every grant.
    always_comb begin
        g0    = 1'b0;
        g1    = 1'b0;
        ptr_d = ptr_q;
        if (en_i) begin
            if (req0_i && req1_i) begin
                if (RR_EN && ptr_q) begin
                    g1 = 1'b1;
                end else begin
                    g0 = 1'b1;
                end
            end else begin
                g0 = req0_i;
                g1 = req1_i;
            end
        end
        if (g0) begin
            ptr_d = 1'b1;
        end else if (g1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt0_o = g0;
    assign gnt1_o = g1;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one data memory, one transaction at a time,
// sequencing the registered read/write strobes the memory samples on.
module dmem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [2:0]        p0_memop,
    input  logic              p0_we,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [2:0]        p1_memop,
    input  logic              p1_we,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,

    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_datain,
    output logic [2:0]        dmem_memop,
    output logic              dmem_we,
    output logic              dmem_rdclk,
    output logic              dmem_wrclk,
    input  logic [31:0]       dmem_dataout
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        memop_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              rdclk_q;
    logic              rdclk_d;
    logic              wrclk_q;
    logic              wrclk_d;

    logic              arb_en;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_memop;
    logic              acc_we;
    logic              acc_mis;
    logic              resp;
    logic [31:0]       resp_rdata;

    // Ready is gated by reset so nothing is accepted while reset is held low.
    assign arb_en = (state_q == IDLE) && reset;

    dmem_rr_arb #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk_i    (clk),
        .reset_ni (reset),
        .en_i     (arb_en),
        .req0_i   (p0_valid),
        .req1_i   (p1_valid),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    always_comb begin
        accept    = gnt0 | gnt1;
        acc_addr  = gnt1 ? p1_addr  : p0_addr;
        acc_wdata = gnt1 ? p1_wdata : p0_wdata;
        acc_memop = gnt1 ? p1_memop : p0_memop;
        acc_we    = gnt1 ? p1_we    : p0_we;
        acc_mis   = is_misaligned(acc_memop, acc_addr[1:0]);
    end

    // Misaligned requests skip straight to RESP so the memory is never touched.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = acc_mis ? RESP : SETUP;
                end
            end
            SETUP:   state_d = RD;
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdclk_d = (state_d == RD);
        wrclk_d = (state_d == WR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            memop_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rdclk_q <= 1'b0;
            wrclk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdclk_q <= rdclk_d;
            wrclk_q <= wrclk_d;
            if (accept) begin
                owner_q <= gnt1;
                addr_q  <= acc_addr;
                wdata_q <= acc_wdata;
                memop_q <= acc_memop;
                we_q    <= acc_we;
                err_q   <= acc_mis;
            end
            if ((state_q == RD) && !we_q) begin
                rdata_q <= dmem_dataout;
            end
        end
    end

    assign resp       = (state_q == RESP);
    assign resp_rdata = (resp && !we_q && !err_q) ? rdata_q : 32'h0;

    assign p0_ready  = gnt0;
    assign p1_ready  = gnt1;
    assign p0_rvalid = resp && !owner_q;
    assign p1_rvalid = resp && owner_q;
    assign p0_rdata  = p0_rvalid ? resp_rdata : 32'h0;
    assign p1_rdata  = p1_rvalid ? resp_rdata : 32'h0;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;

    // Address/data/memop stay latched for the whole transaction; we is qualified by state.
    assign dmem_addr   = addr_q;
    assign dmem_datain = wdata_q;
    assign dmem_memop  = memop_q;
    assign dmem_we     = we_q && ((state_q == SETUP) || (state_q == RD) || (state_q == WR));
    assign dmem_rdclk  = rdclk_q;
    assign dmem_wrclk  = wrclk_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written arbitration and
// reset sequences, then random traffic against a byte-array reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [2:0]  p0_memop;
    logic        p1_valid, p1_ready, p1_we, p1_rvalid, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [2:0]  p1_memop;
    logic [31:0] dmem_addr, dmem_datain;
    logic [31:0] dmem_dataout = 32'h0;
    logic [2:0]  dmem_memop;
    logic        dmem_we, dmem_rdclk, dmem_wrclk;

    logic        fpP0Valid, fpP0Ready, fpP0Rvalid, fpP0Err;
    logic        fpP1Valid, fpP1Ready, fpP1Rvalid, fpP1Err;
    logic [31:0] fpP0Rdata, fpP1Rdata, fpDmemAddr, fpDmemDatain;
    logic [2:0]  fpDmemMemop;
    logic        fpDmemWe, fpDmemRdclk, fpDmemWrclk;
    logic [31:0] fpZero = 32'h0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdCount = 0;
    int wrCount = 0;
    int violations = 0;
    bit logGrants = 0;
    int grantLog[$];

    logic [7:0] mem [0:4095] = '{default: 8'h00};
    logic [7:0] refMem [0:4095] = '{default: 8'h00};
    logic [11:0] memA0, memA1, memA2, memA3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_memop(p0_memop), .p0_we(p0_we), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_memop(p1_memop), .p1_we(p1_we), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .dmem_addr(dmem_addr), .dmem_datain(dmem_datain), .dmem_memop(dmem_memop), .dmem_we(dmem_we),
        .dmem_rdclk(dmem_rdclk), .dmem_wrclk(dmem_wrclk), .dmem_dataout(dmem_dataout)
    );

    dmem_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) dutFp (
        .clk(clk), .reset(reset),
        .p0_valid(fpP0Valid), .p0_ready(fpP0Ready), .p0_addr(fpZero), .p0_wdata(fpZero),
        .p0_memop(3'b010), .p0_we(1'b0), .p0_rvalid(fpP0Rvalid), .p0_rdata(fpP0Rdata), .p0_err(fpP0Err),
        .p1_valid(fpP1Valid), .p1_ready(fpP1Ready), .p1_addr(fpZero), .p1_wdata(fpZero),
        .p1_memop(3'b010), .p1_we(1'b0), .p1_rvalid(fpP1Rvalid), .p1_rdata(fpP1Rdata), .p1_err(fpP1Err),
        .dmem_addr(fpDmemAddr), .dmem_datain(fpDmemDatain), .dmem_memop(fpDmemMemop), .dmem_we(fpDmemWe),
        .dmem_rdclk(fpDmemRdclk), .dmem_wrclk(fpDmemWrclk), .dmem_dataout(fpZero)
    );

    // Cycle counter used to measure accept-to-response latency.
    always @(posedge clk) cyc <= cyc + 1;

    assign memA0 = dmem_addr[11:0];
    assign memA1 = memA0 + 12'd1;
    assign memA2 = memA0 + 12'd2;
    assign memA3 = memA0 + 12'd3;

    // Little-endian memory returning extended load data, as the real data memory does.
    function automatic logic [31:0] envRead(input logic [2:0] op);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[memA0]; b1 = mem[memA1]; b2 = mem[memA2]; b3 = mem[memA3];
        case (op)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge dmem_rdclk) begin
        rdCount <= rdCount + 1;
        dmem_dataout <= envRead(dmem_memop);
    end

    // The memory only commits a write while dmem_we is asserted.
    always @(posedge dmem_wrclk) begin
        wrCount <= wrCount + 1;
        if (dmem_we) begin
            mem[memA0] <= dmem_datain[7:0];
            if (dmem_memop[1:0] != 2'b00) mem[memA1] <= dmem_datain[15:8];
            if (dmem_memop[1]) begin
                mem[memA2] <= dmem_datain[23:16];
                mem[memA3] <= dmem_datain[31:24];
            end
        end
    end

    // Protocol watchdog plus grant logger, sampled mid-cycle well after input changes.
    always @(negedge clk) begin
        #2;
        if ((p0_ready && p1_ready) || (p0_rvalid && p1_rvalid) || (dmem_rdclk && dmem_wrclk))
            violations <= violations + 1;
        if (logGrants) begin
            if (p0_ready) grantLog.push_back(0);
            if (p1_ready) grantLog.push_back(1);
        end
    end

    function automatic int accessBytes(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit refMisaligned(input logic [2:0] op, input logic [31:0] addr);
        if (op == 3'b001 || op == 3'b101) return (addr % 2) != 0;
        if (op == 3'b010) return (addr % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] addr, input logic [2:0] op);
        longint v;
        int n;
        n = accessBytes(op);
        v = 0;
        for (int b = 0; b < n; b++) v += longint'(refMem[(addr + b) % 4096]) << (8 * b);
        if (!op[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic refWrite(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] data);
        for (int b = 0; b < accessBytes(op); b++) refMem[(addr + b) % 4096] = 8'((data >> (8 * b)) & 32'hFF);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic drivePort(input int port, input logic v, input logic we, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_memop = op; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = v; p1_we = we; p1_memop = op; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic er, output logic otherRv,
                                 output int tAcc, output int tRsp);
        bit seen;
        rd = '0; er = 1'b0; otherRv = 1'b0; tAcc = 0; tRsp = -100;
        @(negedge clk);
        drivePort(port, 1'b1, we, op, addr, wdata);
        #1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) begin seen = 1; break; end
            @(negedge clk); #1;
        end
        tAcc = cyc;
        if (!seen) begin
            checks++; failures++;
            $display("[TB] FAIL accept timeout port%0d actual=no ready required=ready", port);
            drivePort(port, 1'b0, we, op, addr, wdata);
            return;
        end
        @(posedge clk); #1;
        drivePort(port, 1'b0, we, op, addr, wdata);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if ((port == 0) ? p0_rvalid : p1_rvalid) begin
                rd      = (port == 0) ? p0_rdata : p1_rdata;
                er      = (port == 0) ? p0_err : p1_err;
                otherRv = (port == 0) ? p1_rvalid : p0_rvalid;
                tRsp    = cyc;
                seen    = 1;
                break;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("[TB] FAIL response timeout port%0d actual=no rvalid required=rvalid", port);
        end
    endtask

    task automatic runVector(input string tag, input int port, input logic we, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] expRd, input logic expErr, input int expLat);
        int rd0, wr0, tAcc, tRsp;
        logic [31:0] rd;
        logic er, other;
        rd0 = rdCount; wr0 = wrCount;
        applyStimulus(port, we, op, addr, wdata, rd, er, other, tAcc, tRsp);
        checkOutput({tag, " rdata"}, rd, expRd);
        checkOutput({tag, " err"}, 32'(er), 32'(expErr));
        checkOutput({tag, " latency"}, 32'(tRsp - tAcc), 32'(expLat));
        checkOutput({tag, " rdclk pulses"}, 32'(rdCount - rd0), expErr ? 32'd0 : 32'd1);
        checkOutput({tag, " wrclk pulses"}, 32'(wrCount - wr0), (we && !expErr) ? 32'd1 : 32'd0);
        checkOutput({tag, " other rvalid"}, 32'(other), 32'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[13];
    logic [2:0] loadOps[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        logic [31:0] rdA, rdB, expRd, addr, wdata;
        logic erA, erB, oA, oB, we, expErr, rvSeen;
        logic [2:0] op;
        int accA, accB, rspA, rspB, port, lat, g0, g1, wr0;
        bit seen;

        reset = 1'b1;
        drivePort(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        drivePort(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        fpP0Valid = 1'b0; fpP1Valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        checkOutput("reset ready gated", 32'(p0_ready), 32'd0);
        checkOutput("reset rvalid", 32'(p0_rvalid), 32'd0);
        checkOutput("reset rdclk", 32'(dmem_rdclk), 32'd0);
        checkOutput("reset wrclk", 32'(dmem_wrclk), 32'd0);
        checkOutput("reset dmem_we", 32'(dmem_we), 32'd0);
        checkOutput("reset dmem_addr", dmem_addr, 32'd0);
        p0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        vecs[0]  = '{0, 1'b1, 3'b010, 32'h100, 32'h12345678, 32'h0,        1'b0, 4};
        vecs[1]  = '{0, 1'b0, 3'b010, 32'h100, 32'h0,        32'h12345678, 1'b0, 3};
        vecs[2]  = '{1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 1};
        vecs[3]  = '{1, 1'b1, 3'b001, 32'h300, 32'h00008001, 32'h0,        1'b0, 4};
        vecs[4]  = '{1, 1'b0, 3'b001, 32'h300, 32'h0,        32'hFFFF8001, 1'b0, 3};
        vecs[5]  = '{1, 1'b0, 3'b101, 32'h300, 32'h0,        32'h00008001, 1'b0, 3};
        vecs[6]  = '{0, 1'b1, 3'b000, 32'h303, 32'h000000F0, 32'h0,        1'b0, 4};
        vecs[7]  = '{0, 1'b0, 3'b010, 32'h300, 32'h0,        32'hF0008001, 1'b0, 3};
        vecs[8]  = '{0, 1'b0, 3'b000, 32'h303, 32'h0,        32'hFFFFFFF0, 1'b0, 3};
        vecs[9]  = '{0, 1'b1, 3'b010, 32'h101, 32'hDEADBEEF, 32'h0,        1'b1, 1};
        vecs[10] = '{1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h12345678, 1'b0, 3};
        vecs[11] = '{0, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        1'b0, 4};
        vecs[12] = '{1, 1'b0, 3'b001, 32'h201, 32'h0,        32'h0,        1'b1, 1};
        for (int i = 0; i < 13; i++)
            runVector($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].op, vecs[i].addr,
                      vecs[i].wdata, vecs[i].expRd, vecs[i].expErr, vecs[i].expLat);

        // Simultaneous store and load to the same byte straight out of reset.
        applyReset();
        fork
            applyStimulus(0, 1'b1, 3'b000, 32'h101, 32'h000000AA, rdA, erA, oA, accA, rspA);
            applyStimulus(1, 1'b0, 3'b100, 32'h101, 32'h0, rdB, erB, oB, accB, rspB);
        join
        checkOutput("tie p0 first", 32'(accA < accB), 32'd1);
        checkOutput("tie p0 first cycle", 32'(accA), 32'(accB - 5));
        checkOutput("tie p1 after p0 rvalid", 32'(accB), 32'(rspA + 1));
        checkOutput("tie p1 lbu rdata", rdB, 32'h000000AA);
        runVector("sb neighbours", 0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234AA78, 1'b0, 3);

        // Round-robin alternation with both ports continuously requesting.
        applyReset();
        grantLog.delete();
        logGrants = 1;
        fork
            for (int k = 0; k < 3; k++)
                applyStimulus(0, 1'b0, 3'b010, 32'h400, 32'h0, rdA, erA, oA, accA, rspA);
            for (int k = 0; k < 3; k++)
                applyStimulus(1, 1'b0, 3'b010, 32'h480, 32'h0, rdB, erB, oB, accB, rspB);
        join
        logGrants = 0;
        checkOutput("rr grant count", 32'(grantLog.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("rr grant%0d", k),
                        (k < grantLog.size()) ? 32'(grantLog[k]) : 32'hFFFF, 32'(k % 2));

        // Fixed priority: port 0 takes every grant.
        g0 = 0; g1 = 0;
        @(negedge clk);
        fpP0Valid = 1'b1; fpP1Valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            #2;
            if (fpP0Ready) g0++;
            if (fpP1Ready) g1++;
            if (g0 + g1 >= 6) break;
            @(negedge clk);
        end
        fpP0Valid = 1'b0; fpP1Valid = 1'b0;
        checkOutput("fp port0 grants", 32'(g0), 32'd6);
        checkOutput("fp port1 grants", 32'(g1), 32'd0);

        // Reset while a halfword store is in its read-modify-write fetch.
        wr0 = wrCount;
        @(negedge clk);
        drivePort(0, 1'b1, 1'b1, 3'b001, 32'h202, 32'h0000BEEF);
        #1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (p0_ready) begin seen = 1; break; end
            @(negedge clk); #1;
        end
        checkOutput("rst sh accepted", 32'(seen), 32'd1);
        @(posedge clk); #1;
        drivePort(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk); #1;
        checkOutput("rst rdclk in RD", 32'(dmem_rdclk), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst rdclk cleared", 32'(dmem_rdclk), 32'd0);
        checkOutput("rst we cleared", 32'(dmem_we), 32'd0);
        rvSeen = 1'b0;
        repeat (3) begin @(negedge clk); #1; rvSeen |= p0_rvalid | p1_rvalid; end
        reset = 1'b1;
        repeat (6) begin @(negedge clk); #1; rvSeen |= p0_rvalid | p1_rvalid; end
        checkOutput("rst no rvalid", 32'(rvSeen), 32'd0);
        checkOutput("rst no wrclk", 32'(wrCount - wr0), 32'd0);
        runVector("rst prior word", 0, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 3);

        // Random single-port traffic checked against the byte-array reference.
        for (int i = 0; i < 40; i++) begin
            port  = $urandom_range(0, 1);
            we    = 1'($urandom_range(0, 1));
            op    = we ? loadOps[$urandom_range(0, 2)] : loadOps[$urandom_range(0, 4)];
            addr  = 32'h400 + $urandom_range(0, 255);
            wdata = $urandom;
            if (refMisaligned(op, addr)) begin
                expRd = 32'h0; expErr = 1'b1; lat = 1;
            end else if (we) begin
                refWrite(addr, op, wdata);
                expRd = 32'h0; expErr = 1'b0; lat = 4;
            end else begin
                expRd = refRead(addr, op); expErr = 1'b0; lat = 3;
            end
            runVector($sformatf("rnd%0d", i), port, we, op, addr, wdata, expRd, expErr, lat);
        end

        repeat (2) @(negedge clk);
        checkOutput("protocol violations", 32'(violations), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of requester and memory address buses.
REQ-002 Parameter: RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 always winning.
REQ-003 clk  in  1  single block clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 p0_valid / p1_valid  in  1  request present (port 0 = CPU data side, port 1 = loader/debug).
REQ-006 p0_ready / p1_ready  out  1  request accepted this cycle.
REQ-007 p0_addr / p1_addr  in  ADDR_W  byte address.
REQ-008 p0_wdata / p1_wdata  in  32  store data, LSB-aligned.
REQ-009 p0_memop / p1_memop  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-010 p0_we / p1_we  in  1  1 = store, 0 = load.
REQ-011 p0_rvalid / p1_rvalid  out  1  one-cycle response strobe.
REQ-012 p0_rdata / p1_rdata  out  32  load result, valid with rvalid; 0 for stores.
REQ-013 p0_err / p1_err  out  1  misaligned access, valid with rvalid.
REQ-014 dmem_addr, dmem_datain  out  ADDR_W, 32  address and data to the data memory.
REQ-015 dmem_memop, dmem_we  out  3, 1  operation to the data memory.
REQ-016 dmem_rdclk, dmem_wrclk  out  1  registered memory strobes; the memory samples on their rising edges.
REQ-017 dmem_dataout  in  32  extended load data from the memory.

Function
REQ-018 FSM states: IDLE, SETUP, RD, WR, RESP; exactly one transaction is in flight.
REQ-019 IDLE: if any valid, grant one port; ready is combinational, high only for the granted port, and only in IDLE.
REQ-020 On grant, latch addr/wdata/memop/we and owner id.
REQ-021 Arbitration (RR_EN=1): sole requester wins; both requesting -> pointer port wins; pointer flips to the loser after every grant; pointer resets to 0.
REQ-022 Misalignment: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0 -> IDLE->RESP; no dmem strobe; err=1; rdata=0.
REQ-023 SETUP: drive latched request on dmem_*; dmem_we = latched we; both strobes low.
REQ-024 RD: dmem_rdclk=1, the read edge, also the read-modify-write fetch for stores; capture dmem_dataout at end of cycle.
REQ-025 WR (stores only): dmem_rdclk=0, dmem_wrclk=1; the write edge.
REQ-026 RESP: owner rvalid=1 for exactly one cycle; rdata = captured value for loads, 0 for stores; err=0; next state IDLE.
REQ-027 Latency from accept cycle T: load rvalid at T+3, store at T+4, misaligned at T+1; the next accept is possible at the rvalid cycle +1.
REQ-028 dmem_addr/datain/memop/we stay stable from SETUP through the last strobe cycle; dmem_we=0 outside SETUP/RD/WR.
REQ-029 Undefined memop codes (011, 110, 111) pass through unchanged; the response follows the normal timing.
REQ-030 The non-owner port sees ready=0 and rvalid=0 for the whole transaction.

Reset
REQ-031 On reset low, immediately: state IDLE, pointer 0, dmem_rdclk=dmem_wrclk=dmem_we=0, all other outputs 0.
REQ-032 On reset mid-transaction, the transaction is dropped with no response; a store reset before WR never writes.
REQ-033 After reset release, the first grant is possible on the first clk edge.

Structure
REQ-034 Shared package rv32_mem_pkg: memop encodings, FSM state encoding, misalignment-check function.
REQ-035 One sub-module dmem_rr_arb holds grant logic and pointer; the FSM and datapath stay in dmem_arbiter.

Verification
REQ-036 Port 0 sw 0x12345678 @0x100, then lw @0x100 -> store rvalid at T+4; load rvalid at T+3 with rdata=0x12345678; one wrclk pulse total.
REQ-037 Both valid from reset, port 0 sb 0xAA @0x101, port 1 lbu @0x101 -> port 0 granted first, port 1 next; p1_rdata=0x000000AA; other bytes unchanged.
REQ-038 Both valid continuously for 6 grants -> grants alternate 0,1,0,1,0,1; with RR_EN=0, all six go to port 0.
REQ-039 Port 1 lw @0x102 -> p1_rvalid at T+1, err=1, rdata=0; no rdclk/wrclk pulse.
REQ-040 Port 0 sh 0xBEEF @0x202, reset low during RD -> no wrclk pulse, no rvalid; a later lw @0x200 returns the prior contents.
REQ-041 Port 1 lh of 0x8001 @0x300 -> rdata=0xFFFF8001; the same with lhu -> 0x00008001.
